// File: rtl/tug_referee.sv
// Tug-of-war referee: tracks the rope position, scores rounds and games, and
// pulses winrnd/wingame for the sound controller.
module tug_referee #(
  parameter int WINS = 3,
  parameter int HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       slowen,
  input  logic       pbl,
  input  logic       pbr,
  input  logic       sypush,
  output logic [3:0] pos,
  output logic [1:0] scorel,
  output logic [1:0] scorer,
  output logic       winner,
  output logic       winrnd,
  output logic       wingame
);

  typedef enum logic [1:0] {
    PLAY,
    HOLD_RND,
    GAMEOVER
  } state_t;

  localparam logic [1:0] WINS_L   = 2'(WINS);
  localparam logic [7:0] HOLD_END = 8'(HOLD - 1);
  localparam logic [3:0] CENTRE   = 4'd4;
  localparam logic [3:0] LEFT_END = 4'd0;
  localparam logic [3:0] RIGHT_END = 4'd8;

  state_t     state;
  logic [7:0] hold_cnt;
  logic       pbl_q;
  logic       pbr_q;
  logic       sy_q;
  logic       armed;
  logic       pbl_edge;
  logic       pbr_edge;
  logic       sy_edge;

  // The first clock after reset release only loads the previous-value
  // registers, so a button already held at release never counts as an edge.
  assign pbl_edge = armed & pbl & ~pbl_q;
  assign pbr_edge = armed & pbr & ~pbr_q;
  assign sy_edge  = armed & sypush & ~sy_q;

  // Referee state machine: rope movement, round decisions, hold timing and restart.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= PLAY;
      pos      <= CENTRE;
      scorel   <= 2'd0;
      scorer   <= 2'd0;
      winner   <= 1'b0;
      winrnd   <= 1'b0;
      wingame  <= 1'b0;
      hold_cnt <= 8'd0;
      pbl_q    <= 1'b0;
      pbr_q    <= 1'b0;
      sy_q     <= 1'b0;
      armed    <= 1'b0;
    end else begin
      pbl_q   <= pbl;
      pbr_q   <= pbr;
      sy_q    <= sypush;
      armed   <= 1'b1;
      winrnd  <= 1'b0;
      wingame <= 1'b0;
      if (sy_edge) begin
        state    <= PLAY;
        pos      <= CENTRE;
        scorel   <= 2'd0;
        scorer   <= 2'd0;
        hold_cnt <= 8'd0;
      end else begin
        case (state)
          PLAY: begin
            if (pos == LEFT_END) begin
              winner <= 1'b0;
              scorel <= scorel + 2'd1;
              if (scorel + 2'd1 == WINS_L) begin
                wingame <= 1'b1;
                state   <= GAMEOVER;
              end else begin
                winrnd   <= 1'b1;
                hold_cnt <= 8'd0;
                state    <= HOLD_RND;
              end
            end else if (pos == RIGHT_END) begin
              winner <= 1'b1;
              scorer <= scorer + 2'd1;
              if (scorer + 2'd1 == WINS_L) begin
                wingame <= 1'b1;
                state   <= GAMEOVER;
              end else begin
                winrnd   <= 1'b1;
                hold_cnt <= 8'd0;
                state    <= HOLD_RND;
              end
            end else if (pbl_edge && !pbr_edge) begin
              pos <= pos - 4'd1;
            end else if (pbr_edge && !pbl_edge) begin
              pos <= pos + 4'd1;
            end
          end
          HOLD_RND: begin
            if (slowen) begin
              if (hold_cnt == HOLD_END) begin
                hold_cnt <= 8'd0;
                pos      <= CENTRE;
                state    <= PLAY;
              end else begin
                hold_cnt <= hold_cnt + 8'd1;
              end
            end
          end
          GAMEOVER: begin
            state <= GAMEOVER;
          end
          default: begin
            state <= PLAY;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tug_referee.sv
// Testbench for tug_referee: directed vector table, hand-written multi-cycle
// scenarios, and randomized play checked against a round-level reference model.
module tb_tug_referee;

  localparam int WINS = 3;
  localparam int HOLD = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       slowen = 1'b0;
  logic       pbl = 1'b0;
  logic       pbr = 1'b0;
  logic       sypush = 1'b0;
  logic [3:0] pos;
  logic [1:0] scorel;
  logic [1:0] scorer;
  logic       winner;
  logic       winrnd;
  logic       wingame;

  int checks = 0;
  int passes = 0;

  // Reference model: rope position as an integer, scores as integers, and a
  // countdown of remaining slow ticks while a round win is being shown.
  int m_pos;
  int m_sl;
  int m_sr;
  int m_hold_left;
  bit m_win;
  bit m_wr;
  bit m_wg;
  bit m_over;
  bit m_armed;
  bit m_pl;
  bit m_pr;
  bit m_ps;

  typedef struct {
    bit l;
    bit r;
    bit s;
    bit e;
    int pos;
    int wr;
    int wg;
    int sl;
    int sr;
    int win;
  } vec_t;

  vec_t tab[12];

  tug_referee #(.WINS(WINS), .HOLD(HOLD)) dut (
    .clk(clk),
    .rst(rst),
    .slowen(slowen),
    .pbl(pbl),
    .pbr(pbr),
    .sypush(sypush),
    .pos(pos),
    .scorel(scorel),
    .scorer(scorer),
    .winner(winner),
    .winrnd(winrnd),
    .wingame(wingame)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic modelReset();
    m_pos = 4; m_sl = 0; m_sr = 0; m_hold_left = 0;
    m_win = 0; m_wr = 0; m_wg = 0; m_over = 0;
    m_armed = 0; m_pl = 0; m_pr = 0; m_ps = 0;
  endtask

  // One clock of referee behaviour, from the game rules.
  task automatic modelStep();
    bit el, er, es;
    el = m_armed && pbl && !m_pl;
    er = m_armed && pbr && !m_pr;
    es = m_armed && sypush && !m_ps;
    m_wr = 0;
    m_wg = 0;
    if (es) begin
      m_pos = 4; m_sl = 0; m_sr = 0; m_hold_left = 0; m_over = 0;
    end else if (m_over) begin
      m_over = 1;
    end else if (m_hold_left > 0) begin
      if (slowen) begin
        m_hold_left--;
        if (m_hold_left == 0) m_pos = 4;
      end
    end else if (m_pos == 0 || m_pos == 8) begin
      int sc;
      m_win = (m_pos == 8);
      if (m_win) begin m_sr++; sc = m_sr; end
      else begin m_sl++; sc = m_sl; end
      if (sc == WINS) begin m_wg = 1; m_over = 1; end
      else begin m_wr = 1; m_hold_left = HOLD; end
    end else begin
      m_pos = m_pos + int'(er) - int'(el);
    end
    m_pl = pbl; m_pr = pbr; m_ps = sypush; m_armed = 1;
  endtask

  task automatic checkModel();
    checks++;
    if (int'(pos) == m_pos && int'(scorel) == m_sl && int'(scorer) == m_sr &&
        winner == m_win && winrnd == m_wr && wingame == m_wg)
      passes++;
    else
      $display("[TB] FAIL model t=%0t: got pos=%0d sl=%0d sr=%0d win=%0b wr=%0b wg=%0b, expected pos=%0d sl=%0d sr=%0d win=%0b wr=%0b wg=%0b",
               $time, pos, scorel, scorer, winner, winrnd, wingame,
               m_pos, m_sl, m_sr, m_win, m_wr, m_wg);
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    checkModel();
  endtask

  task automatic applyStimulus(input bit l, input bit r, input bit s, input bit e);
    pbl = l; pbr = r; sypush = s; slowen = e;
    tick();
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    checkVal({tag, " pos"}, int'(pos), v.pos);
    checkVal({tag, " winrnd"}, int'(winrnd), v.wr);
    checkVal({tag, " wingame"}, int'(wingame), v.wg);
    checkVal({tag, " scorel"}, int'(scorel), v.sl);
    checkVal({tag, " scorer"}, int'(scorer), v.sr);
    checkVal({tag, " winner"}, int'(winner), v.win);
  endtask

  task automatic checkResetValues(input string tag);
    checkVal({tag, " pos"}, int'(pos), 4);
    checkVal({tag, " scores"}, int'({scorel, scorer}), 0);
    checkVal({tag, " winner"}, int'(winner), 0);
    checkVal({tag, " pulses"}, int'({winrnd, wingame}), 0);
  endtask

  // Pull reset low mid-cycle, check outputs without any clock edge, then release.
  task automatic midReset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    checkResetValues(tag);
    modelReset();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0);
  endtask

  task automatic pushRight(input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0);
    end
  endtask

  initial begin
    tab[0]  = '{1, 1, 0, 0, 4, 0, 0, 0, 0, 0};
    tab[1]  = '{0, 0, 0, 0, 4, 0, 0, 0, 0, 0};
    tab[2]  = '{1, 0, 0, 0, 3, 0, 0, 0, 0, 0};
    tab[3]  = '{0, 0, 0, 0, 3, 0, 0, 0, 0, 0};
    tab[4]  = '{1, 0, 0, 0, 2, 0, 0, 0, 0, 0};
    tab[5]  = '{0, 0, 0, 0, 2, 0, 0, 0, 0, 0};
    tab[6]  = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    tab[7]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    tab[8]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tab[9]  = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 0};
    tab[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    tab[11] = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0};

    modelReset();
    #12;
    checkResetValues("reset");
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(tab[i].l, tab[i].r, tab[i].s, tab[i].e);
      checkOutput($sformatf("vec%0d", i), tab[i]);
    end

    // Round hold: pushes ignored, return to centre on the HOLD-th slow tick.
    for (int i = 1; i <= HOLD; i++) begin
      applyStimulus(0, i % 2, 0, 1);
      checkVal($sformatf("hold%0d pos", i), int'(pos), (i == HOLD) ? 4 : 0);
      applyStimulus(0, 0, 0, 0);
    end
    applyStimulus(1, 0, 0, 0);
    checkVal("after hold play pos", int'(pos), 3);
    applyStimulus(0, 0, 0, 0);
    pushRight(1);

    // Right player wins three rounds.
    for (int rnd = 1; rnd <= 3; rnd++) begin
      pushRight(4);
      checkVal($sformatf("rnd%0d winrnd", rnd), int'(winrnd), (rnd < 3) ? 1 : 0);
      checkVal($sformatf("rnd%0d wingame", rnd), int'(wingame), (rnd == 3) ? 1 : 0);
      checkVal($sformatf("rnd%0d scorer", rnd), int'(scorer), rnd);
      checkVal($sformatf("rnd%0d winner", rnd), int'(winner), 1);
      if (rnd < 3) begin
        for (int i = 0; i < HOLD; i++) begin
          applyStimulus(0, 0, 0, 1);
          applyStimulus(0, 0, 0, 0);
        end
        checkVal($sformatf("rnd%0d recentre", rnd), int'(pos), 4);
      end
    end
    applyStimulus(0, 0, 0, 0);
    checkVal("wingame one cycle", int'(wingame), 0);
    pushRight(3);
    checkVal("gameover frozen pos", int'(pos), 8);
    checkVal("gameover scorer", int'(scorer), 3);

    // New game from game over.
    applyStimulus(0, 0, 1, 0);
    checkVal("restart pos", int'(pos), 4);
    checkVal("restart scores", int'({scorel, scorer}), 0);
    checkVal("restart winner kept", int'(winner), 1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkVal("restart then pbl", int'(pos), 3);

    // Restart arriving with a winning push beats the win.
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkVal("pre-priority pos", int'(pos), 1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 1, 0);
    checkVal("priority pos", int'(pos), 4);
    applyStimulus(0, 0, 0, 0);
    checkVal("priority no pulse", int'({winrnd, wingame}), 0);
    checkVal("priority scorel", int'(scorel), 0);

    // Randomized play against the model.
    for (int i = 0; i < 4000; i++) begin
      applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0);
    end
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0);

    // Reset while winrnd is high.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
    end
    checkVal("pre-reset winrnd", int'(winrnd), 1);
    midReset("reset mid-pulse");
    applyStimulus(0, 1, 0, 0);
    checkVal("post-reset pbr pos", int'(pos), 5);

    // Reset during the round hold.
    applyStimulus(0, 0, 0, 0);
    pushRight(3);
    checkVal("pre-reset2 winrnd", int'(winrnd), 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    midReset("reset mid-hold");
    applyStimulus(0, 1, 0, 0);
    checkVal("post-reset2 pbr pos", int'(pos), 5);
    applyStimulus(0, 0, 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
